lzrw1_group_packer: RTL
=======================

LZRW1_GROUP_PACKER -- requirements
Module: lzrw1_group_packer

Interface
REQ-001 Parameter GROUP_ITEMS, default 16: items per LZRW1 group; SHALL be 8 or 16; control word width = GROUP_ITEMS bits.
REQ-002 Port clock  input  1: sole clock; all state updates on posedge clock.
REQ-003 Port reset  input  1: synchronous, active-high reset.
REQ-004 Port in_valid  input  1: upstream item present.
REQ-005 Port in_ready  output  1: packer accepts an item this cycle; transfer when in_valid & in_ready.
REQ-006 Port in_copy  input  1: 1 = copy item, 0 = literal item.
REQ-007 Port in_byte  input  8: literal byte; ignored when in_copy=1.
REQ-008 Port in_length  input  4: copy length field; ignored when in_copy=0.
REQ-009 Port in_offset  input  12: copy offset; ignored when in_copy=0.
REQ-010 Port in_last  input  1: item is the final item of the stream; closes the current group.
REQ-011 Port out_valid  output  1: out_data holds a valid byte.
REQ-012 Port out_ready  input  1: downstream accepts; byte transfers when out_valid & out_ready.
REQ-013 Port out_data  output  8: compressed stream byte.
REQ-014 Port out_last  output  1: high with the final byte of a group closed by in_last.
REQ-015 Port busy  output  1: high whenever state is not FILL.

Function
REQ-016 FSM states: FILL, CTRL_LO, CTRL_HI, DATA; CTRL_HI exists only when GROUP_ITEMS=16 (GROUP_ITEMS=8 goes CTRL_LO -> DATA).
REQ-017 FILL: in_ready=1, out_valid=0; every accepted item appends its bytes to the group buffer (depth 2*GROUP_ITEMS bytes) and sets control bit [item_index] = in_copy.
REQ-018 Literal encoding: one byte, in_byte.
REQ-019 Copy encoding: two bytes, first {in_length, in_offset[11:8]}, then in_offset[7:0].
REQ-020 Group closes on the handshake of item GROUP_ITEMS, or on any handshake with in_last=1; FSM enters CTRL_LO on the following edge.
REQ-021 Control bits for unfilled positions of a partial group are 0.
REQ-022 CTRL_LO emits control[7:0], CTRL_HI emits control[15:8], then DATA emits buffered bytes in acceptance order.
REQ-023 in_ready=0 in all states except FILL.
REQ-024 Latency: the group-closing item is accepted at edge N; out_valid=1 with the control low byte during cycle N+1.
REQ-025 State advances only on an output handshake; while out_valid=1 and out_ready=0, out_data and out_last hold stable.
REQ-026 After the final DATA byte handshake, clear item count, byte count, control word and last flag; return to FILL; in_ready=1 next cycle.
REQ-027 out_last=1 only on the final DATA byte of a group closed by in_last; 0 on control bytes and on all other bytes.
REQ-028 Counters: item index 0..GROUP_ITEMS, byte count 0..2*GROUP_ITEMS; no wrap is possible; byte read pointer stops at byte count.
REQ-029 A group closed by in_last on its first item is still emitted: control bytes plus 1 or 2 data bytes.

Reset
REQ-030 reset=1 at an edge forces state FILL, in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0, and clears counters and control word; it takes priority over all other activity.
REQ-031 Reset mid-group or mid-emission discards buffered data; nothing partial is emitted afterwards.

Structure
REQ-032 Shared package lzrw1_pkg SHALL hold the item struct (copy, byte, length, offset), the state enum, and the LZRW1 length/offset width constants.
REQ-033 One sub-module, lzrw1_item_encoder, SHALL map an item to {byte0, byte1, nbytes}; buffer and FSM stay in the top.

Verification
REQ-034 Literal 0x41, then copy len=3 off=0x123 with in_last, out_ready=1 -> bytes 0x02,0x00,0x41,0x31,0x23; out_last only on 0x23.
REQ-035 16 literals 0x00..0x0F, no in_last -> 0x00,0x00,0x00..0x0F; out_last never set; in_ready low for exactly 18 cycles.
REQ-036 16 copies len=0xF off=0xFFF -> 0xFF,0xFF, then 16 pairs 0xFF,0xFF (34 bytes); second group accepted immediately after.
REQ-037 REQ-034 stimulus with out_ready toggling randomly -> identical byte sequence; out_data stable while stalled.
REQ-038 Reset asserted during DATA of a 16-item group -> out_valid=0 next cycle, in_ready=1; the next group starts with fresh control bytes.
REQ-039 Single copy len=1 off=0x000 with in_last -> 0x01,0x00,0x10,0x00; out_last on the final 0x00.

Source files
------------

// File: rtl/lzrw1_pkg.sv
// Shared LZRW1 item definitions, field widths and packer state encoding.
package lzrw1_pkg;

   localparam int LEN_W  = 4;
   localparam int OFF_W  = 12;
   localparam int BYTE_W = 8;

   typedef struct packed {
      logic              copy;
      logic [BYTE_W-1:0] lit;
      logic [LEN_W-1:0]  length;
      logic [OFF_W-1:0]  offset;
   } item_t;

   typedef enum logic [1:0] {
      FILL    = 2'd0,
      CTRL_LO = 2'd1,
      CTRL_HI = 2'd2,
      DATA    = 2'd3
   } state_e;

endpackage

// File: rtl/lzrw1_item_encoder.sv
// Maps one LZRW1 item to its on-stream bytes: a literal is one byte,
// a copy is {length, offset[11:8]} followed by offset[7:0].
module lzrw1_item_encoder
   import lzrw1_pkg::*;
(
   input  item_t       item_i,
   output logic [7:0]  byte0_o,
   output logic [7:0]  byte1_o,
   output logic [1:0]  nbytes_o
);

   always_comb begin
      byte0_o  = item_i.lit;
      byte1_o  = 8'h00;
      nbytes_o = 2'd1;
      if (item_i.copy) begin
         byte0_o  = {item_i.length, item_i.offset[OFF_W-1:8]};
         byte1_o  = item_i.offset[7:0];
         nbytes_o = 2'd2;
      end
   end

endmodule

// File: rtl/lzrw1_group_packer.sv
// Collects LZRW1 items into a group, then emits the control word (low byte
// first) followed by the buffered item bytes in acceptance order.
//
// state   | meaning
// FILL    | accepting items into the group buffer
// CTRL_LO | emitting control[7:0]
// CTRL_HI | emitting control[15:8] (16-item groups only)
// DATA    | emitting buffered bytes up to the byte count
module lzrw1_group_packer
   import lzrw1_pkg::*;
#(
   parameter int GROUP_ITEMS = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_copy,
   input  logic [7:0]  in_byte,
   input  logic [3:0]  in_length,
   input  logic [11:0] in_offset,
   input  logic        in_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_data,
   output logic        out_last,
   output logic        busy
);

   localparam int DEPTH = 2 * GROUP_ITEMS;
   localparam int AW    = $clog2(DEPTH);
   localparam int BW    = $clog2(DEPTH + 1);
   localparam int CW    = $clog2(GROUP_ITEMS);
   localparam int IW    = $clog2(GROUP_ITEMS + 1);

   state_e                 state_q, state_d;
   logic [IW-1:0]          item_cnt_q, item_cnt_d;
   logic [BW-1:0]          byte_cnt_q, byte_cnt_d;
   logic [BW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [GROUP_ITEMS-1:0] ctrl_q, ctrl_d;
   logic                   last_q, last_d;
   logic [7:0]             data_buf_q [DEPTH];

   item_t          in_item;
   logic [7:0]     enc_b0, enc_b1;
   logic [1:0]     enc_n;
   logic           in_fire, out_fire, rd_final;
   logic [IW-1:0]  item_next;
   logic [AW-1:0]  wr_idx, wr_idx1;
   logic [15:0]    ctrl_ext;

   assign in_item = '{copy: in_copy, lit: in_byte, length: in_length, offset: in_offset};

   lzrw1_item_encoder u_enc (
      .item_i   (in_item),
      .byte0_o  (enc_b0),
      .byte1_o  (enc_b1),
      .nbytes_o (enc_n)
   );

   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   assign item_next = item_cnt_q + IW'(1);
   assign rd_final  = (rd_ptr_q + BW'(1)) == byte_cnt_q;
   assign wr_idx    = byte_cnt_q[AW-1:0];
   assign wr_idx1   = wr_idx + AW'(1);
   assign busy      = (state_q != FILL);

   always_comb begin
      state_d    = state_q;
      item_cnt_d = item_cnt_q;
      byte_cnt_d = byte_cnt_q;
      rd_ptr_d   = rd_ptr_q;
      ctrl_d     = ctrl_q;
      last_d     = last_q;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      out_data   = 8'h00;
      out_last   = 1'b0;
      ctrl_ext   = 16'h0000;
      ctrl_ext[GROUP_ITEMS-1:0] = ctrl_q;

      case (state_q)
         FILL: begin
            in_ready = 1'b1;
            if (in_fire) begin
               ctrl_d[item_cnt_q[CW-1:0]] = in_copy;
               item_cnt_d = item_next;
               byte_cnt_d = byte_cnt_q + BW'(enc_n);
               if (item_next == IW'(GROUP_ITEMS) || in_last) begin
                  state_d = CTRL_LO;
                  last_d  = in_last;
               end
            end
         end
         CTRL_LO: begin
            out_valid = 1'b1;
            out_data  = ctrl_ext[7:0];
            if (out_fire) begin
               rd_ptr_d = '0;
               state_d  = (GROUP_ITEMS == 16) ? CTRL_HI : DATA;
            end
         end
         CTRL_HI: begin
            out_valid = 1'b1;
            out_data  = ctrl_ext[15:8];
            if (out_fire) state_d = DATA;
         end
         DATA: begin
            out_valid = 1'b1;
            out_data  = data_buf_q[rd_ptr_q[AW-1:0]];
            out_last  = last_q & rd_final;
            if (out_fire) begin
               if (rd_final) begin
                  // Group fully drained: start the next one from a clean slate.
                  state_d    = FILL;
                  item_cnt_d = '0;
                  byte_cnt_d = '0;
                  rd_ptr_d   = '0;
                  ctrl_d     = '0;
                  last_d     = 1'b0;
               end else begin
                  rd_ptr_d = rd_ptr_q + BW'(1);
               end
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= FILL;
         item_cnt_q <= '0;
         byte_cnt_q <= '0;
         rd_ptr_q   <= '0;
         ctrl_q     <= '0;
         last_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         item_cnt_q <= item_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         rd_ptr_q   <= rd_ptr_d;
         ctrl_q     <= ctrl_d;
         last_q     <= last_d;
      end
   end

   // Buffer contents are only meaningful below byte_cnt_q, so no reset here.
   always_ff @(posedge clock) begin
      if (in_fire) begin
         data_buf_q[wr_idx] <= enc_b0;
         if (enc_n == 2'd2) data_buf_q[wr_idx1] <= enc_b1;
      end
   end

endmodule
